// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: host-side PS/2 keyboard receiver.
// Deserialises 11-bit device-clocked frames, tracks the E0/F0 prefixes,
// strobes completed scancodes and keeps level key-state outputs for two keys.
//
// Handshake: oScanValid and oFrameErr are single-cycle strobes with no ready.
// oScanCode, oBreak and oExtended are valid in the oScanValid cycle and hold
// their values until the next strobe. The strobes are never high together.
module ps2_key_decoder #(
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  KEY1_CODE      = 8'h16,
    parameter logic [7:0]  KEY2_CODE      = 8'h1E
) (
    input  logic       clk,
    input  logic       iResetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       one_pressed_out,
    output logic       two_pressed_out,
    output logic [7:0] oScanCode,
    output logic       oScanValid,
    output logic       oBreak,
    output logic       oExtended,
    output logic       oFrameErr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Synchroniser and edge-detect flops
    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;

    // Frame and decode state
    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic          one_q, one_d;
    logic          two_q, two_d;
    logic [7:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          break_q, break_d;
    logic          extended_q, extended_d;
    logic          err_q, err_d;

    logic          fe;
    logic          frame_good;

    assign fe         = clk_prev_q & ~clk_s2_q;
    assign frame_good = dat_s2_q & (^{shreg_q, parity_q});

    // Two-flop synchronisers on both PS/2 lines plus the previous clock sample
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            clk_s1_q   <= 1'b0;
            clk_s2_q   <= 1'b0;
            clk_prev_q <= 1'b0;
            dat_s1_q   <= 1'b0;
            dat_s2_q   <= 1'b0;
        end else begin
            clk_s1_q   <= PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= PS2_DAT;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // Frame FSM state register and registered decode outputs
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            to_cnt_q   <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            one_q      <= 1'b0;
            two_q      <= 1'b0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            break_q    <= 1'b0;
            extended_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            to_cnt_q   <= to_cnt_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            one_q      <= one_d;
            two_q      <= two_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            break_q    <= break_d;
            extended_q <= extended_d;
            err_q      <= err_d;
        end
    end

    // Next-state, frame evaluation and key-state update
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        to_cnt_d   = '0;
        ext_d      = ext_q;
        brk_d      = brk_q;
        one_d      = one_q;
        two_d      = two_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        break_d    = break_q;
        extended_d = extended_q;
        err_d      = 1'b0;

        // Inactivity counter only runs while a frame is in flight
        if (state_q != IDLE && !fe) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A high start bit is noise; ignore it silently
                if (fe && !dat_s2_q) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                end
            end
            DATA: begin
                if (fe) begin
                    shreg_d[bitcnt_q] = dat_s2_q;
                    bitcnt_d          = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fe) begin
                    parity_d = dat_s2_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fe) begin
                    state_d = IDLE;
                    if (!frame_good) begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end else if (shreg_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shreg_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        valid_d    = 1'b1;
                        code_d     = shreg_q;
                        break_d    = brk_q;
                        extended_d = ext_q;
                        ext_d      = 1'b0;
                        brk_d      = 1'b0;
                        // Extended codes share make codes with plain keys; skip them
                        if (!ext_q && shreg_q == KEY1_CODE) begin
                            one_d = ~brk_q;
                        end
                        if (!ext_q && shreg_q == KEY2_CODE) begin
                            two_d = ~brk_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abandon a stalled frame; prefix flags survive so the sequence can resume
        if (state_q != IDLE && !fe && to_cnt_q == TO_LAST) begin
            err_d    = 1'b1;
            state_d  = IDLE;
            to_cnt_d = '0;
        end
    end

    assign one_pressed_out = one_q;
    assign two_pressed_out = two_q;
    assign oScanCode       = code_q;
    assign oScanValid      = valid_q;
    assign oBreak          = break_q;
    assign oExtended       = extended_q;
    assign oFrameErr       = err_q;

endmodule
